// File: rtl/mac_user_pkg.sv
// Shared types and constants for the 1G MAC user-side packers/readers.
package mac_user_pkg;

  localparam int unsigned MIN_BYTES_DEF = 60;
  localparam int unsigned WORD_W        = 32;

  localparam logic [1:0] BE_4B = 2'b00;
  localparam logic [1:0] BE_1B = 2'b01;
  localparam logic [1:0] BE_2B = 2'b10;
  localparam logic [1:0] BE_3B = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [1:0]        be;
    logic              sop;
    logic              eop;
  } mac_word_t;

  // Byte-enable code for a final word whose last valid byte sits at lane idx.
  function automatic logic [1:0] be_encode(input logic [1:0] idx);
    logic [1:0] be;
    case (idx)
      2'd0:    be = BE_1B;
      2'd1:    be = BE_2B;
      2'd2:    be = BE_3B;
      default: be = BE_4B;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mac_tx_word_reg.sv
// Single-entry word holding register with the MAC wa/wr handshake.
module mac_tx_word_reg
  import mac_user_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      load_i,
  input  mac_word_t word_i,
  input  logic      wa_i,
  output logic      valid_o,
  output logic      wr_o,
  output mac_word_t word_o
);

  logic      valid_q, valid_d;
  mac_word_t word_q, word_d;
  logic      drain;

  assign drain = valid_q & wa_i;

  // Load wins over drain so a same-cycle drain/close reloads without a bubble;
  // a plain drain clears the payload so flags never show on an empty register.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
    end else if (drain) begin
      valid_d = 1'b0;
      word_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid_o = valid_q;
  assign wr_o    = drain;
  assign word_o  = word_q;

endmodule

// File: rtl/mac_tx_packer.sv
// Packs an 8-bit packet stream into big-endian 32-bit MAC Tx words,
// zero-padding runt packets up to MIN_BYTES.
module mac_tx_packer
  import mac_user_pkg::*;
#(
  parameter int unsigned MIN_BYTES = MIN_BYTES_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk_user,
  input  logic             Reset,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [7:0]       In_data,
  input  logic             In_last,
  input  logic             Tx_mac_wa,
  output logic             Tx_mac_wr,
  output logic [31:0]      Tx_mac_data,
  output logic [1:0]       Tx_mac_BE,
  output logic             Tx_mac_sop,
  output logic             Tx_mac_eop,
  output logic             Busy,
  output logic             Pkt_done,
  output logic [CNT_W-1:0] Pkt_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_pend_q, len_pend_d;
  logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
  logic [31:0]      asm_q, asm_d;
  logic [1:0]       idx_q, idx_d;
  logic             sop_pend_q, sop_pend_d;
  logic             pkt_done_q, pkt_done_d;

  logic             out_valid, out_drain, load;
  mac_word_t        out_word, word_new;

  logic [CNT_W-1:0] cnt_inc;
  logic             fill_done, in_phase, byte_last, closing, can_accept, byte_ev;
  logic [7:0]       bval;
  logic [31:0]      asm_ins;

  // Byte-stream side: accept/pad decision and word assembly.
  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    fill_done  = 32'(cnt_inc) >= MIN_BYTES;
    in_phase   = (state_q != ST_PAD);
    byte_last  = in_phase ? (In_last & fill_done) : fill_done;
    closing    = (idx_q == 2'd3) | byte_last;
    can_accept = !(closing & out_valid & !out_drain);
    In_ready   = in_phase & can_accept;
    byte_ev    = in_phase ? (In_valid & can_accept) : can_accept;
    bval       = in_phase ? In_data : 8'h00;
    asm_ins    = asm_q | (32'(bval) << {~idx_q, 3'b000});
  end

  // Next-state: FSM, counters, assembly register and completion status.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_pend_d = len_pend_q;
    pkt_len_d  = pkt_len_q;
    asm_d      = asm_q;
    idx_d      = idx_q;
    sop_pend_d = sop_pend_q;
    pkt_done_d = 1'b0;
    load       = 1'b0;
    word_new   = '0;

    if (byte_ev) begin
      cnt_d = cnt_inc;
      if (closing) begin
        load          = 1'b1;
        word_new.data = asm_ins;
        word_new.sop  = sop_pend_q | (state_q == ST_IDLE);
        word_new.eop  = byte_last;
        word_new.be   = byte_last ? be_encode(idx_q) : BE_4B;
        asm_d         = '0;
        idx_d         = 2'd0;
        sop_pend_d    = 1'b0;
      end else begin
        asm_d = asm_ins;
        idx_d = idx_q + 2'd1;
        if (state_q == ST_IDLE) sop_pend_d = 1'b1;
      end
      if (byte_last) begin
        cnt_d      = '0;
        len_pend_d = cnt_inc;
      end

      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (In_last) state_d = fill_done ? ST_IDLE : ST_PAD;
          else         state_d = ST_DATA;
        end
        ST_PAD:  if (fill_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (out_drain & out_word.eop) begin
      pkt_done_d = 1'b1;
      pkt_len_d  = len_pend_q;
    end
  end

  always_ff @(posedge Clk_user) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_pend_q <= '0;
      pkt_len_q  <= '0;
      asm_q      <= '0;
      idx_q      <= 2'd0;
      sop_pend_q <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_pend_q <= len_pend_d;
      pkt_len_q  <= pkt_len_d;
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      sop_pend_q <= sop_pend_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  mac_tx_word_reg u_word_reg (
    .clk_i   (Clk_user),
    .rst_i   (Reset),
    .load_i  (load),
    .word_i  (word_new),
    .wa_i    (Tx_mac_wa),
    .valid_o (out_valid),
    .wr_o    (out_drain),
    .word_o  (out_word)
  );

  assign Tx_mac_wr   = out_drain;
  assign Tx_mac_data = out_word.data;
  assign Tx_mac_BE   = out_word.be;
  assign Tx_mac_sop  = out_word.sop;
  assign Tx_mac_eop  = out_word.eop;
  assign Busy        = (state_q != ST_IDLE) | out_valid;
  assign Pkt_done    = pkt_done_q;
  assign Pkt_len     = pkt_len_q;

endmodule

// File: tb/tb_mac_tx_packer.sv
// Directed and randomized bench for mac_tx_packer with a packet-level reference model.
module tb_mac_tx_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_last  [2];
  logic [7:0]  in_data  [2];
  logic        wa       [2];
  logic        in_ready [2];
  logic        tx_wr    [2];
  logic [31:0] tx_data  [2];
  logic [1:0]  tx_be    [2];
  logic        tx_sop   [2];
  logic        tx_eop   [2];
  logic        busy     [2];
  logic        pkt_done [2];
  logic [15:0] pkt_len  [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit stall_mode;

  logic [35:0] wq0[$], wq1[$];
  logic [15:0] lq0[$], lq1[$];
  logic [7:0]  exp_bytes[$];
  logic [35:0] exp_words[$];
  int          exp_len;
  logic [35:0] prev_w [2];
  logic        prev_wa[2];
  logic [35:0] mon_cur;

  always #5 clk = ~clk;

  mac_tx_packer #(.MIN_BYTES(0), .CNT_W(16)) dut0 (
    .Clk_user(clk), .Reset(rst), .In_valid(in_valid[0]), .In_ready(in_ready[0]),
    .In_data(in_data[0]), .In_last(in_last[0]), .Tx_mac_wa(wa[0]), .Tx_mac_wr(tx_wr[0]),
    .Tx_mac_data(tx_data[0]), .Tx_mac_BE(tx_be[0]), .Tx_mac_sop(tx_sop[0]),
    .Tx_mac_eop(tx_eop[0]), .Busy(busy[0]), .Pkt_done(pkt_done[0]), .Pkt_len(pkt_len[0])
  );

  mac_tx_packer #(.MIN_BYTES(60), .CNT_W(16)) dut1 (
    .Clk_user(clk), .Reset(rst), .In_valid(in_valid[1]), .In_ready(in_ready[1]),
    .In_data(in_data[1]), .In_last(in_last[1]), .Tx_mac_wa(wa[1]), .Tx_mac_wr(tx_wr[1]),
    .Tx_mac_data(tx_data[1]), .Tx_mac_BE(tx_be[1]), .Tx_mac_sop(tx_sop[1]),
    .Tx_mac_eop(tx_eop[1]), .Busy(busy[1]), .Pkt_done(pkt_done[1]), .Pkt_len(pkt_len[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect written words and completion pulses; check words hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        prev_w[d]  = '0;
        prev_wa[d] = 1'b1;
      end
    end else begin
      if (tx_wr[0]) wq0.push_back({tx_data[0], tx_be[0], tx_sop[0], tx_eop[0]});
      if (tx_wr[1]) wq1.push_back({tx_data[1], tx_be[1], tx_sop[1], tx_eop[1]});
      if (pkt_done[0]) lq0.push_back(pkt_len[0]);
      if (pkt_done[1]) lq1.push_back(pkt_len[1]);
      for (int d = 0; d < 2; d++) begin
        mon_cur = {tx_data[d], tx_be[d], tx_sop[d], tx_eop[d]};
        if (stall_mode && !prev_wa[d] && prev_w[d] != '0)
          check("hold_while_stalled", 64'(mon_cur), 64'(prev_w[d]));
        prev_w[d]  = mon_cur;
        prev_wa[d] = wa[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) wa[d] = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic build(input int len, input int base, input int step, input bit rnd);
    exp_bytes.delete();
    for (int k = 0; k < len; k++)
      exp_bytes.push_back(rnd ? 8'($urandom_range(1, 255)) : 8'(base + step * k));
  endtask

  // Reference: pad to the minimum, cut into big-endian 4-byte words, flag ends.
  task automatic model(input int mn);
    logic [7:0]  b[$];
    logic [35:0] w;
    int n, nw;
    b = exp_bytes;
    n = (b.size() > mn) ? b.size() : mn;
    while (b.size() < n) b.push_back(8'h00);
    nw = (n + 3) / 4;
    exp_len = n;
    exp_words.delete();
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < n) w[35 - 8 * j -: 8] = b[4 * i + j];
      w[1]   = (i == 0);
      w[0]   = (i == nw - 1);
      w[3:2] = (i == nw - 1) ? 2'(n % 4) : 2'b00;
      exp_words.push_back(w);
    end
  endtask

  task automatic send(input int d, input int stop_at);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < exp_bytes.size() && i != stop_at) begin
      in_valid[d] = 1'b1;
      in_data[d]  = exp_bytes[i];
      in_last[d]  = (i == exp_bytes.size() - 1);
      @(negedge clk);
      acc = in_ready[d];
      if (stall_mode && !acc) check("ready_drop_needs_wa_low", 64'(wa[d]), 64'd0);
      tick();
      if (acc) i++;
      guard++;
      if (guard > 4000) begin
        check("send_timeout", 64'(i), 64'(exp_bytes.size()));
        break;
      end
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic finish_pkt(input int d, input string tag);
    int          g = 0;
    logic [35:0] got;
    model((d == 0) ? 0 : 60);
    while (((d == 0) ? lq0.size() : lq1.size()) == 0 && g < 3000) begin
      tick();
      g++;
    end
    tick();
    tick();
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy[d]), 64'd0);
    check({tag, "_done_pulses"}, 64'((d == 0) ? lq0.size() : lq1.size()), 64'd1);
    if (d == 0) got = (lq0.size() > 0) ? 36'(lq0[0]) : 36'hF_FFFF_FFFF;
    else        got = (lq1.size() > 0) ? 36'(lq1[0]) : 36'hF_FFFF_FFFF;
    check({tag, "_pkt_len"}, 64'(got), 64'(exp_len));
    check({tag, "_nwords"}, 64'((d == 0) ? wq0.size() : wq1.size()), 64'(exp_words.size()));
    for (int k = 0; k < exp_words.size(); k++) begin
      got = 36'hF_FFFF_FFFF;
      if (d == 0 && wq0.size() > 0) got = wq0.pop_front();
      if (d == 1 && wq1.size() > 0) got = wq1.pop_front();
      check($sformatf("%s_word%0d", tag, k), 64'(got), 64'(exp_words[k]));
    end
    wq0.delete(); wq1.delete(); lq0.delete(); lq1.delete();
    tick();
  endtask

  task automatic reset_chk(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_wr", tag, d),     64'(tx_wr[d]),    64'd0);
      check($sformatf("%s_d%0d_data", tag, d),   64'(tx_data[d]),  64'd0);
      check($sformatf("%s_d%0d_be", tag, d),     64'(tx_be[d]),    64'd0);
      check($sformatf("%s_d%0d_sop", tag, d),    64'(tx_sop[d]),   64'd0);
      check($sformatf("%s_d%0d_eop", tag, d),    64'(tx_eop[d]),   64'd0);
      check($sformatf("%s_d%0d_busy", tag, d),   64'(busy[d]),     64'd0);
      check($sformatf("%s_d%0d_done", tag, d),   64'(pkt_done[d]), 64'd0);
      check($sformatf("%s_d%0d_len", tag, d),    64'(pkt_len[d]),  64'd0);
      check($sformatf("%s_d%0d_ready", tag, d),  64'(in_ready[d]), 64'd1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    stall_mode = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
      in_data[d]  = 8'h00;
      wa[d]       = 1'b1;
    end
    tick();
    tick();
    @(negedge clk);
    reset_chk("reset");
    tick();
    rst = 1'b0;
    tick();

    // 8 bytes 01..08, no padding
    build(8, 8'h01, 1, 1'b0);
    send(0, -1);
    finish_pkt(0, "p8");

    // 5 bytes AA..EE, partial final word
    build(5, 8'hAA, 8'h11, 1'b0);
    send(0, -1);
    finish_pkt(0, "p5");

    // single byte padded to 60; ready must stay low while padding
    build(1, 8'h55, 0, 1'b0);
    send(1, -1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("pad_ready_c%0d", c), 64'(in_ready[1]), 64'd0);
      tick();
    end
    finish_pkt(1, "p1pad");

    // 61 bytes 00..3C, above minimum
    build(61, 8'h00, 1, 1'b0);
    send(1, -1);
    finish_pkt(1, "p61");

    // random write-allow stalls over a 64-byte packet on both instances
    stall_mode = 1'b1;
    build(64, 0, 0, 1'b1);
    send(1, -1);
    finish_pkt(1, "stall64_d1");
    build(64, 0, 0, 1'b1);
    send(0, -1);
    finish_pkt(0, "stall64_d0");
    stall_mode = 1'b0;

    // randomized lengths, data and stall enable
    for (int t = 0; t < 8; t++) begin
      stall_mode = 1'($urandom_range(0, 1));
      build($urandom_range(1, 80), 0, 0, 1'b1);
      send(t % 2, -1);
      finish_pkt(t % 2, $sformatf("rnd%0d", t));
    end
    stall_mode = 1'b0;
    tick();

    // reset in the middle of a packet, then a clean packet
    build(30, 8'h80, 1, 1'b0);
    send(0, 20);
    rst = 1'b1;
    tick();
    @(negedge clk);
    reset_chk("midreset");
    tick();
    rst = 1'b0;
    wq0.delete(); wq1.delete(); lq0.delete(); lq1.delete();
    tick();
    build(8, 8'h11, 1, 1'b0);
    send(0, -1);
    finish_pkt(0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tx_packer.md
Name: mac_tx_packer

Overview:
- User-side byte-stream source for the 1G MAC transmit user interface; drives Tx_mac_wr/data/BE/sop/eop and obeys Tx_mac_wa.
- Packs an 8-bit packet stream into 32-bit big-endian words.
- Zero-pads runt packets to MIN_BYTES.
- Sits in the Clk_user domain between the application packet generator and the MAC top.

Parameters:
- MIN_BYTES, 60: minimum frame bytes before FCS; shorter packets are zero-padded; 0 disables padding. Legal range 0..65535.
- CNT_W, 16: width of the byte counter and Pkt_len.

Ports:
- Clk_user  in  1  user clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- In_valid  in  1  input byte valid.
- In_ready  out  1  byte accepted when In_valid & In_ready.
- In_data  in  8  payload byte; first byte is the destination MAC MSB.
- In_last  in  1  marks the final byte of the packet; qualified by In_valid.
- Tx_mac_wa  in  1  MAC FIFO write allowed.
- Tx_mac_wr  out  1  word write strobe.
- Tx_mac_data  out  32  word; first byte in [31:24].
- Tx_mac_BE  out  2  valid bytes on the eop word: 00=4, 01=1, 10=2, 11=3; 00 on non-eop words.
- Tx_mac_sop  out  1  first word of the packet.
- Tx_mac_eop  out  1  last word of the packet.
- Busy  out  1  packet in progress or output word pending.
- Pkt_done  out  1  one-cycle pulse when the eop word is written.
- Pkt_len  out  CNT_W  padded byte count of the last completed packet; valid from the Pkt_done cycle.

Behaviour:
- Reset: all outputs 0 except In_ready, which is 1.
  - FSM returns to IDLE; the byte counter, assembly register and output register are cleared.
  - A partially sent packet is abandoned with no eop; the MAC side is reset together with this block.
- FSM states:
  - IDLE: accept bytes; the first accepted byte sets sop_pending and moves to DATA.
  - DATA: accept bytes. A byte with In_last moves to PAD if count+1 < MIN_BYTES, else back to IDLE.
  - PAD: In_ready=0; generate one 0x00 byte per cycle (subject to can_accept) until count = MIN_BYTES; the final pad byte is treated as last; then IDLE.
  - Single-byte packet: a byte with In_last accepted in IDLE goes directly to PAD, or to IDLE when MIN_BYTES ≤ 1.
- Assembly register: 32 bits plus a 2-bit index.
  - Byte k of a word goes into bits [31-8k -: 8].
  - A word closes when index==3 or the byte is last.
  - On close, the word moves to the output register; sop and eop flags and BE = byte_count mod 4 encoding go with it.
- Output register: single entry, out_valid.
  - drain = out_valid & Tx_mac_wa.
  - Tx_mac_wr = drain (combinational AND with Tx_mac_wa).
  - Tx_mac_data, BE, sop and eop are registered and held stable while out_valid & !Tx_mac_wa.
  - Tx_mac_sop/eop/BE may be nonzero only while out_valid; BE is 00 unless eop.
- Backpressure:
  - can_accept = !(closing_word & out_valid & !drain).
  - In_ready = (state != PAD) & can_accept.
  - The pad generator advances only on can_accept.
  - Throughput: 1 byte/cycle; a word closes at most every cycle.
- Byte counter: counts accepted and pad bytes, saturating at 2^CNT_W-1.
  - Captured into Pkt_len when the eop word is written.
  - Cleared on entry to IDLE after the final byte.
- Back-to-back packets:
  - The first byte of the next packet may be accepted the cycle after the last byte, subject to can_accept.
  - sop is never merged into the previous packet's eop word.
- Simultaneous events:
  - A drain and a new word close in the same cycle: the output register reloads with no bubble.
  - Reset overrides everything.

Decomposition:
- Shared package mac_user_pkg:
  - BE encoding constants BE_4B=2'b00, BE_1B=2'b01, BE_2B=2'b10, BE_3B=2'b11.
  - FSM state encoding ST_IDLE, ST_DATA, ST_PAD.
  - Default MIN_BYTES constant.
- One sub-module, mac_tx_word_reg: the single-entry output holding register with the wa/wr handshake, reusable for the Rx reader. Everything else stays in the top.

Test Plan:
- 8-byte packet 01..08, Tx_mac_wa=1, MIN_BYTES=0:
  - Word 0x01020304 with sop=1, eop=0, BE=00.
  - Word 0x05060708 with sop=0, eop=1, BE=00.
  - Pkt_done pulses; Pkt_len=8.
- 5-byte packet AA..EE, MIN_BYTES=0:
  - Word 0xAABBCCDD with sop.
  - Word 0xEE000000 with eop, BE=01; Pkt_len=5.
- 1-byte packet 0x55, MIN_BYTES=60:
  - 15 words; the first is 0x55000000 with sop; words 2..14 are 0; the 15th has eop, BE=00.
  - In_ready=0 during PAD; Pkt_len=60.
- 61-byte incrementing packet, MIN_BYTES=60:
  - No padding; 16 words; the last word is 0x3C000000 with eop, BE=01; Pkt_len=61.
- Stall: toggle Tx_mac_wa 1-0-0-1 randomly during a 64-byte packet.
  - No word is lost or duplicated; data is stable while wa=0.
  - In_ready drops only when a closing word would collide.
  - The received byte sequence is identical to the sent one.
- Reset asserted mid-packet at byte 20, then a fresh 8-byte packet:
  - All outputs are 0 in the cycle after reset.
  - The next packet begins with sop and no stale data.
